// File: rtl/phase_sequencer.sv
// phase_sequencer: debounced exec start/stop, free-run / single-step / halt
// sequencing of the instruction phase counter with an instruction counter.
module phase_sequencer #(
   parameter int NUM_PHASES = 5,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 exec,
   input  logic                 step_mode,
   input  logic                 stall,
   input  logic                 halt_req,
   output logic [2:0]           phase,
   output logic                 running,
   output logic                 halted,
   output logic                 instr_done,
   output logic [CNT_WIDTH-1:0] instr_count
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;
   state_t state, state_n;
   logic sync1, sync2, db, db_d, exec_pulse, stop_pending, stop_n, adv, bnd;
   logic [DW-1:0] db_cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         db           <= 1'b0;
         db_d         <= 1'b0;
         db_cnt       <= '0;
         exec_pulse   <= 1'b0;
         state        <= IDLE;
         stop_pending <= 1'b0;
         phase        <= 3'd0;
         instr_done   <= 1'b0;
         instr_count  <= '0;
      end else begin
         sync1        <= exec;
         sync2        <= sync1;
         db_d         <= db;
         exec_pulse   <= db & ~db_d;
         if (sync2 == db) db_cnt <= '0;
         else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            db     <= sync2;
            db_cnt <= '0;
         end else db_cnt <= db_cnt + 1'b1;
         state        <= state_n;
         stop_pending <= stop_n;
         phase        <= bnd ? 3'd0 : phase + 3'(adv);
         instr_done   <= bnd;
         instr_count  <= instr_count + CNT_WIDTH'(bnd);
      end
   end
   // a boundary is an unstalled advance out of the last phase
   always_comb begin
      adv     = (state == RUN || state == STEP) && !stall;
      bnd     = adv && phase == 3'(NUM_PHASES - 1);
      state_n = state;
      stop_n  = stop_pending;
      case (state)
         IDLE: if (exec_pulse) state_n = step_mode ? STEP : RUN;
         RUN: begin
            stop_n = stop_pending | exec_pulse;
            if (bnd && (halt_req || stop_pending)) begin
               state_n = halt_req ? HALTED : IDLE;
               stop_n  = 1'b0;
            end
         end
         STEP: if (bnd) state_n = halt_req ? HALTED : IDLE;
         default: ;
      endcase
   end
   assign running = state == RUN || state == STEP;
   assign halted  = state == HALTED;
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the 3-bit instruction `phase` consumed by the phase decoder in `control_unit`, which turns it into the one-hot p1–p5 enables. Runs in three modes: free-running, single-instruction step, and halt.
- Start/stop is requested by the front-panel `exec` pushbutton; this block synchronizes and debounces it.
- The datapath can hold the current phase with `stall` and request a halt with `halt_req`.
- Sits between the board inputs and `control_unit`. Also exports `running` and an instruction counter for the display.

## Interface
- `NUM_PHASES`, default 5: phases per instruction; phase counts 0..NUM_PHASES-1, range 2..8.
- `DEBOUNCE_CYCLES`, default 65536: consecutive stable samples required to accept an `exec` level change; ≥2.
- `CNT_WIDTH`, default 16: width of `instr_count`.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset, as already decided.
- `exec`  in  1  raw pushbutton, asynchronous, active-high.
- `step_mode`  in  1  level; sampled only on an accepted start in IDLE.
- `stall`  in  1  level; holds the phase when high.
- `halt_req`  in  1  level; sampled only at an instruction boundary.
- `phase`  out  3  current phase, 0..NUM_PHASES-1.
- `running`  out  1  high in RUN or STEP.
- `halted`  out  1  high in HALTED.
- `instr_done`  out  1  one-cycle pulse on each completed instruction.
- `instr_count`  out  CNT_WIDTH  completed instructions, wraps modulo 2^CNT_WIDTH.

## Operation
- **Input conditioning**
  - `exec` passes through a 2-flop synchronizer to give `sync2`.
  - Debounce counter increments each cycle `sync2` ≠ debounced level `db`; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, `db` takes `sync2` and the counter clears.
  - `exec_pulse` is a registered one-cycle pulse on each 0→1 transition of `db`.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- **Advance**: in RUN or STEP with `stall` = 0, `phase` advances by 1 on each edge.
- **Boundary**: an advance from phase NUM_PHASES-1 is a boundary. At a boundary:
  - `phase` goes to 0;
  - `instr_count` increments;
  - `instr_done` pulses in the following cycle;
  - the exit conditions below are evaluated.
- **States**
  - **IDLE**: `phase` = 0, `running` = 0.
    - `exec_pulse` with `step_mode` = 1 → STEP.
    - `exec_pulse` with `step_mode` = 0 → RUN.
  - **RUN**:
    - `exec_pulse` sets `stop_pending`; a second pulse leaves it set.
    - At a boundary, `halt_req` = 1 → HALTED.
    - At a boundary, otherwise `stop_pending` = 1 → IDLE, clearing `stop_pending`.
    - At a boundary, otherwise stay in RUN.
  - **STEP**:
    - `exec_pulse` is ignored.
    - At a boundary, `halt_req` = 1 → HALTED, else → IDLE.
  - **HALTED**:
    - `phase` = 0, `running` = 0, `halted` = 1.
    - `exec_pulse` is ignored; the only exit is `reset`.
- `stall` = 1 on the last phase postpones the boundary; no count, no exit.
- `halt_req` has priority over `stop_pending` at the same boundary; `stop_pending` is cleared on entering HALTED.
- `halt_req` asserted mid-instruction has no effect unless it is still high at the boundary edge.

## Timing
- **Reset values**, all applied at the first edge with `reset` = 1:
  - state IDLE;
  - `phase` = 0, `running` = 0, `halted` = 0, `instr_done` = 0, `instr_count` = 0;
  - `stop_pending` = 0, `db` = 0, debounce counter = 0, synchronizer flops = 0.
- `reset` overrides all other inputs, including mid-instruction and mid-debounce.
- If `exec` is held high through reset, it is accepted DEBOUNCE_CYCLES+2 edges after reset deassertion and produces an `exec_pulse`.
- **`exec` latency**: `sync2` goes high 2 edges after `exec` rises. `db` goes high DEBOUNCE_CYCLES edges later. `exec_pulse` is high for the cycle after that.
- **Start**: on the edge where `exec_pulse` is high in IDLE, the state becomes RUN/STEP. `running` = 1 and `phase` = 0 from that edge. The next unstalled edge advances to phase 1.
- **Unstalled instruction length**: exactly NUM_PHASES cycles.
- **Exits**:
  - `running` falls on the same edge that returns `phase` to 0 at the stopping boundary.
  - `halted` rises on that edge when halting.
- **Outputs**: all outputs are registered; no combinational path from any input to any output.

## Test plan
- **Free run**: DEBOUNCE_CYCLES = 4, NUM_PHASES = 5. Hold `exec` high 10 cycles, `step_mode` = 0.
  - Expect: `running` rises 7 edges after the first sampled high.
  - Expect: `phase` sequence 0,1,2,3,4,0,…
  - Expect: `instr_count` = 3 after 15 run cycles.
- **Stop**: pulse `exec` again while `phase` = 2.
  - Expect: phases 3,4 complete, `instr_count` +1, then IDLE with `phase` = 0 and `running` = 0.
  - Expect: no partial instruction.
- **Step**: `step_mode` = 1, press `exec`.
  - Expect: exactly one 0..4 sequence, one `instr_done`, `instr_count` 0→1, then IDLE.
  - A further `exec` press during STEP → no extra instruction.
- **Stall and halt**: during RUN, assert `stall` for 3 cycles at `phase` = 4.
  - Expect: `phase` holds at 4 for 3 cycles, with no count during the hold.
  - Then assert `halt_req` and `exec` stop together at the boundary → HALTED, `halted` = 1.
  - A subsequent `exec` press has no effect; reset clears to IDLE.
- **Glitch reject / wrap**:
  - A 3-cycle `exec` glitch with DEBOUNCE_CYCLES = 4 → no start.
  - With CNT_WIDTH = 4, 17 instructions → `instr_count` = 1.
- **Reset mid-instruction**: assert `reset` at `phase` = 3 in RUN.
  - Expect next edge: `phase` = 0, `running` = 0, `instr_count` = 0, `instr_done` = 0.
